// File: rtl/peripheral_mpram_pkg.sv
// Shared defaults and sizing helpers for the MPRAM requester arbiter.
package peripheral_mpram_pkg;

  localparam int unsigned NReqDefault  = 4;
  localparam int unsigned ABitsDefault = 10;
  localparam int unsigned DBitsDefault = 32;

  function automatic int unsigned calc_bebits(input int unsigned dbits);
    return (dbits + 7) / 8;
  endfunction

  // A single requester still gets a 1-bit pointer so the register is never zero-width.
  function automatic int unsigned calc_ptr_width(input int unsigned nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/peripheral_mpram_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer, wrapping at NREQ-1.
module peripheral_mpram_rr_arbiter
  import peripheral_mpram_pkg::*;
#(
  parameter int unsigned NREQ = NReqDefault
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam int unsigned PtrW = calc_ptr_width(NREQ);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] gnt;
  logic            found;
  int unsigned     idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        // Explicit modulo keeps non-power-of-two NREQ from walking into unused codes.
        ptr_d    = PtrW'((idx + 1) % NREQ);
      end
    end
  end

  assign gnt_o = rst_ni ? gnt : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/peripheral_mpram_1r1w_arbiter.sv
// Shares one 1R1W memory between NREQ requesters with independent read/write round-robin.
module peripheral_mpram_1r1w_arbiter
  import peripheral_mpram_pkg::*;
#(
  parameter  int unsigned NREQ   = NReqDefault,
  parameter  int unsigned ABITS  = ABitsDefault,
  parameter  int unsigned DBITS  = DBitsDefault,
  localparam int unsigned BEBITS = calc_bebits(DBITS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        wreq_i,
  output logic [NREQ-1:0]        wready_o,
  input  logic [NREQ*ABITS-1:0]  waddr_i,
  input  logic [NREQ*DBITS-1:0]  wdata_i,
  input  logic [NREQ*BEBITS-1:0] wbe_i,
  input  logic [NREQ-1:0]        rreq_i,
  output logic [NREQ-1:0]        rready_o,
  input  logic [NREQ*ABITS-1:0]  raddr_i,
  output logic [NREQ-1:0]        rvalid_o,
  output logic [DBITS-1:0]       rdata_o,
  output logic                   mem_we_o,
  output logic [ABITS-1:0]       mem_waddr_o,
  output logic [DBITS-1:0]       mem_din_o,
  output logic [BEBITS-1:0]      mem_be_o,
  output logic [ABITS-1:0]       mem_raddr_o,
  input  logic [DBITS-1:0]       mem_dout_i
);

  logic [NREQ-1:0] wgnt, rgnt;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  peripheral_mpram_rr_arbiter #(
    .NREQ(NREQ)
  ) u_warb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_i (wreq_i),
    .gnt_o (wgnt)
  );

  peripheral_mpram_rr_arbiter #(
    .NREQ(NREQ)
  ) u_rarb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_i (rreq_i),
    .gnt_o (rgnt)
  );

  assign wready_o = wgnt;
  assign rready_o = rgnt;
  assign mem_we_o = |wgnt;

  // Grants are one-hot, so a priority-free select is sufficient; idle drives zeros.
  always_comb begin
    mem_waddr_o = '0;
    mem_din_o   = '0;
    mem_be_o    = '0;
    mem_raddr_o = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (wgnt[k]) begin
        mem_waddr_o = waddr_i[k*ABITS +: ABITS];
        mem_din_o   = wdata_i[k*DBITS +: DBITS];
        mem_be_o    = wbe_i[k*BEBITS +: BEBITS];
      end
      if (rgnt[k]) begin
        mem_raddr_o = raddr_i[k*ABITS +: ABITS];
      end
    end
  end

  assign rvalid_d = rgnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = mem_dout_i;

endmodule

// File: tb/tb_peripheral_mpram_1r1w_arbiter.sv
// Directed bench: 4-requester instance on a behavioural memory, plus a 3-requester instance.
module tb_peripheral_mpram_1r1w_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned NB = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    wreq, wready, rreq, rready, rvalid;
  logic [N*AW-1:0] waddr, raddr;
  logic [N*DW-1:0] wdata;
  logic [N*BW-1:0] wbe;
  logic [DW-1:0]   rdata, mem_din, mem_dout;
  logic [AW-1:0]   mem_waddr, mem_raddr;
  logic [BW-1:0]   mem_be;
  logic            mem_we;

  peripheral_mpram_1r1w_arbiter #(
    .NREQ (N),
    .ABITS(AW),
    .DBITS(DW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wreq_i     (wreq),
    .wready_o   (wready),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .wbe_i      (wbe),
    .rreq_i     (rreq),
    .rready_o   (rready),
    .raddr_i    (raddr),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .mem_we_o   (mem_we),
    .mem_waddr_o(mem_waddr),
    .mem_din_o  (mem_din),
    .mem_be_o   (mem_be),
    .mem_raddr_o(mem_raddr),
    .mem_dout_i (mem_dout)
  );

  // Behavioural 1R1W memory: byte-enabled write, registered read, no bypass.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_be[b]) mem[mem_waddr][b*8 +: 8] <= mem_din[b*8 +: 8];
      end
    end
    mem_dout <= mem[mem_raddr];
  end

  logic [NB-1:0]    b_wreq, b_wready, b_rreq, b_rready, b_rvalid;
  logic [NB*AW-1:0] b_waddr, b_raddr;
  logic [NB*DW-1:0] b_wdata;
  logic [NB*BW-1:0] b_wbe;
  logic [DW-1:0]    b_rdata, b_mem_din;
  logic [AW-1:0]    b_mem_waddr, b_mem_raddr;
  logic [BW-1:0]    b_mem_be;
  logic             b_mem_we;

  peripheral_mpram_1r1w_arbiter #(
    .NREQ (NB),
    .ABITS(AW),
    .DBITS(DW)
  ) dut_b (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wreq_i     (b_wreq),
    .wready_o   (b_wready),
    .waddr_i    (b_waddr),
    .wdata_i    (b_wdata),
    .wbe_i      (b_wbe),
    .rreq_i     (b_rreq),
    .rready_o   (b_rready),
    .raddr_i    (b_raddr),
    .rvalid_o   (b_rvalid),
    .rdata_o    (b_rdata),
    .mem_we_o   (b_mem_we),
    .mem_waddr_o(b_mem_waddr),
    .mem_din_o  (b_mem_din),
    .mem_be_o   (b_mem_be),
    .mem_raddr_o(b_mem_raddr),
    .mem_dout_i (32'h0)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single write by requester k, checking the grant and memory-side payload.
  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [BW-1:0] be);
    waddr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
    wbe[k*BW +: BW]   = be;
    wreq              = N'(1) << k;
    @(negedge clk);
    check_eq("wr_gnt", wready, N'(1) << k);
    check_eq("wr_addr", mem_waddr, a);
    check_eq("wr_din", mem_din, d);
    check_eq("wr_be", mem_be, be);
    step();
    wreq = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    wreq = '1; rreq = '1;
    waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    b_wreq = '1; b_rreq = '1;
    b_waddr = '0; b_raddr = '0; b_wdata = '0; b_wbe = '0;
    #12;
    check_eq("rst_wready", wready, 0);
    check_eq("rst_rready", rready, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_b_wready", b_wready, 0);
    wreq = '0; rreq = '0; b_wreq = '0; b_rreq = '0;
    #1 rst_n = 1'b1;
    step();

    // Write round-robin with all requesters active; be=0 leaves memory untouched.
    for (int k = 0; k < N; k++) waddr[k*AW +: AW] = AW'(10'h100 + k);
    wreq = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("wrr_gnt", wready, N'(1) << (i % 4));
      check_eq("wrr_addr", mem_waddr, 10'h100 + (i % 4));
      check_eq("wrr_we", mem_we, 1);
      check_eq("wrr_be", mem_be, 0);
      step();
    end
    wreq = '0;
    @(negedge clk);
    check_eq("idle_we", mem_we, 0);
    check_eq("idle_be", mem_be, 0);
    check_eq("idle_addr", mem_waddr, 0);
    step();

    // Read round-robin and one-cycle latency.
    wr(1, 10'h010, 32'hA5A5A5A5, 4'hF);
    raddr[1*AW +: AW] = 10'h010;
    raddr[2*AW +: AW] = 10'h010;
    rreq = 4'b0110;
    @(negedge clk);
    check_eq("rrr_gnt0", rready, 4'b0010);
    check_eq("rrr_raddr", mem_raddr, 10'h010);
    step();
    @(negedge clk);
    check_eq("rrr_gnt1", rready, 4'b0100);
    check_eq("rrr_vld0", rvalid, 4'b0010);
    check_eq("rrr_data0", rdata, 32'hA5A5A5A5);
    step();
    rreq = '0;
    @(negedge clk);
    check_eq("rrr_vld1", rvalid, 4'b0100);
    check_eq("rrr_data1", rdata, 32'hA5A5A5A5);
    step();
    @(negedge clk);
    check_eq("rrr_vld_off", rvalid, 0);

    // Partial byte-enable write.
    wr(0, 10'h003, 32'h11223344, 4'hF);
    wr(2, 10'h003, 32'hAABBCCDD, 4'b0101);
    raddr[3*AW +: AW] = 10'h003;
    rreq = 4'b1000;
    @(negedge clk);
    check_eq("be_rgnt", rready, 4'b1000);
    step();
    rreq = '0;
    @(negedge clk);
    check_eq("be_vld", rvalid, 4'b1000);
    check_eq("be_data", rdata, 32'h11BB33DD);
    step();

    // Same-cycle read and write to one address returns the old word.
    wr(0, 10'h020, 32'h0, 4'hF);
    waddr[1*AW +: AW] = 10'h020;
    wdata[1*DW +: DW] = 32'hDEADBEEF;
    wbe[1*BW +: BW]   = 4'hF;
    wreq = 4'b0010;
    raddr[0*AW +: AW] = 10'h020;
    rreq = 4'b0001;
    @(negedge clk);
    check_eq("col_wgnt", wready, 4'b0010);
    check_eq("col_rgnt", rready, 4'b0001);
    step();
    wreq = '0;
    raddr[1*AW +: AW] = 10'h020;
    rreq = 4'b0010;
    @(negedge clk);
    check_eq("col_vld0", rvalid, 4'b0001);
    check_eq("col_old", rdata, 32'h0);
    check_eq("col_rgnt1", rready, 4'b0010);
    step();
    rreq = '0;
    @(negedge clk);
    check_eq("col_vld1", rvalid, 4'b0010);
    check_eq("col_new", rdata, 32'hDEADBEEF);
    step();

    // Reset while a read response is in flight.
    raddr[2*AW +: AW] = 10'h010;
    rreq = 4'b0100;
    @(negedge clk);
    check_eq("rst_rgnt", rready, 4'b0100);
    step();
    rreq = '0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_kill", rvalid, 0);
    @(negedge clk);
    check_eq("rst_kill2", rvalid, 0);
    #2 rst_n = 1'b1;
    step();
    for (int k = 0; k < N; k++) raddr[k*AW +: AW] = 10'h010;
    rreq = 4'b1111;
    @(negedge clk);
    check_eq("post_rst_gnt", rready, 4'b0001);
    step();
    rreq = '0;
    @(negedge clk);
    check_eq("post_rst_vld", rvalid, 4'b0001);
    check_eq("post_rst_mem", rdata, 32'hA5A5A5A5);
    step();

    // Three requesters: sparse request and explicit pointer wrap.
    b_wreq = 3'b100;
    b_rreq = 3'b100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("b_sparse_w", b_wready, 3'b100);
      check_eq("b_sparse_r", b_rready, 3'b100);
      step();
    end
    b_wreq = 3'b101;
    b_rreq = 3'b101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("b_alt_w", b_wready, (i % 2 == 0) ? 3'b001 : 3'b100);
      check_eq("b_alt_r", b_rready, (i % 2 == 0) ? 3'b001 : 3'b100);
      step();
    end
    b_wreq = '0;
    b_rreq = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/peripheral_mpram_1r1w_arbiter.md
Name: peripheral_mpram_1r1w_arbiter

Overview:
Shares one inferred 1R1W memory between NREQ independent requesters. The memory has byte-enabled writes and a registered read with no bypass.
- Write port and read port are arbitrated separately, each by its own round-robin arbiter.
- The selected request is driven onto the memory pins in the same cycle it is granted.
- Read responses are routed back to the granted requester one cycle later.
- Sits between the AHB3 slave front-ends and the memory wrapper in the MPRAM peripheral.

Parameters:
NREQ, 4, number of requesters (≥1); per-side pointer width is max(1,$clog2(NREQ)).
ABITS, 10, word address width.
DBITS, 32, data width; BEBITS=(DBITS+7)/8 byte enables, with the top lane partial if DBITS%8≠0.

Ports:
clk_i  in  1  clock, all state on rising edge.
rst_ni  in  1  asynchronous active-low reset.
wreq_i  in  NREQ  per-requester write request.
wready_o  out  NREQ  write grant, one-hot or zero.
waddr_i  in  NREQ*ABITS  write addresses, requester k at [k*ABITS+:ABITS].
wdata_i  in  NREQ*DBITS  write data.
wbe_i  in  NREQ*BEBITS  write byte enables.
rreq_i  in  NREQ  per-requester read request.
rready_o  out  NREQ  read grant, one-hot or zero.
raddr_i  in  NREQ*ABITS  read addresses.
rvalid_o  out  NREQ  read response valid, one-hot or zero.
rdata_o  out  DBITS  read response data, shared bus.
mem_we_o  out  1  memory write enable.
mem_waddr_o  out  ABITS  memory write address.
mem_din_o  out  DBITS  memory write data.
mem_be_o  out  BEBITS  memory byte enables.
mem_raddr_o  out  ABITS  memory read address.
mem_dout_i  in  DBITS  memory registered read data.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - wptr=0, rptr=0, rvalid_o=0.
  - wready_o and rready_o are 0 while rst_ni=0, since grants are gated by reset.
- Handshake:
  - A transfer occurs on a cycle where req[k]&ready[k]=1.
  - A requester holds req and payload stable until granted; ready is combinational from req and pointer.
  - Dropping req before grant is allowed; nothing is issued.
- Round-robin arbitration (each side independent):
  - Grant goes to the first asserted req scanning from ptr upward, wrapping from NREQ-1 to 0.
  - After a grant to k, ptr <= (k+1) mod NREQ; with no grant, ptr holds.
  - NREQ not a power of two: the pointer wraps explicitly at NREQ-1, never at 2^width.
  - With all req asserted continuously, each requester is granted exactly once per NREQ cycles. No starvation.
- Write path, same cycle as grant:
  - mem_we_o=|wready_o.
  - mem_waddr_o, mem_din_o and mem_be_o are muxed from the granted requester.
  - With no grant, mem_we_o=0 and mem_be_o=0; address and data are don't-care, driven 0.
  - A grant with wbe=0 is still a completed transfer (we=1, be=0); memory is unchanged.
- Read path:
  - mem_raddr_o is muxed from the granted requester.
  - rvalid_o <= rready_o, a registered copy, so the response arrives exactly 1 cycle after grant.
  - rdata_o=mem_dout_i is passed through and is meaningful only while |rvalid_o.
  - Reads issue back-to-back, one per cycle, with no response backpressure: requesters must accept rvalid.
- Simultaneous read and write to the same address in one cycle: the read returns the OLD data, since the memory has no bypass. No forwarding is done; requesters needing RAW ordering must wait one cycle.
- The same requester may hold a read grant and a write grant in the same cycle.
- Reset mid-operation:
  - An in-flight read response is discarded (rvalid_o forced 0).
  - Pointers return to 0.
  - Memory contents are unaffected.

Decomposition:
- Package peripheral_mpram_pkg:
  - localparams for default NREQ, ABITS and DBITS.
  - A function for BEBITS.
  - A function computing the pointer width.
- Sub-module peripheral_mpram_rr_arbiter #(NREQ):
  - Ports clk_i, rst_ni, req_i, gnt_o; contains the pointer register.
  - Instantiated twice, once for the write side and once for the read side.
- Top level holds the payload muxes and the rvalid register.

Test Plan:
- Write round-robin: NREQ=4; wreq=4'b1111 held 8 cycles after reset → wready sequence 0001,0010,0100,1000,0001,0010,0100,1000; mem_waddr tracks the granted requester.
- Read round-robin and latency: req1 writes 0xA5A5A5A5 @0x010; then rreq=4'b0110 with both reading 0x010 → rready 0010 then 0100; rvalid 0010 then 0100, each one cycle later; rdata=0xA5A5A5A5 on both.
- Byte enables: word @0x3 preset to 0x11223344; write 0xAABBCCDD with be=4'b0101 → readback 0x11BB33DD.
- Same-cycle collision: word @0x20 preset to 0x0; write 0xDEADBEEF @0x20 in the same cycle as a read @0x20 → response 0x00000000; a read the next cycle → 0xDEADBEEF.
- Sparse requests and non-power-of-two: NREQ=3 with only req2 asserted → granted every cycle, pointer wraps 2→0. Then req0 and req2 asserted → alternating grants.
- Reset mid-read: assert rst_ni=0 the cycle after a read grant → rvalid_o=0 immediately; after release, the first grant goes to requester 0.
